alu_cmd_issuer: RTL and testbench

- Command buffer directly upstream of alu_seq.
- Accepts {operand1, operand2, opcode} commands from a producer over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Issues one command per clock to the ALU input ports while issue_en is high.
- Decouples bursty stimulus/producer traffic from the ALU's fixed per-cycle consumption and reports occupancy and issued-command count.

---
 rtl/alu_cmd_issuer.sv | 116 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command FIFO in front of the ALU: buffers {operand1, operand2, opcode} commands
// and issues one per clock into registered ALU inputs while issue_en is high.
module alu_cmd_issuer #(
   parameter int DEPTH = 8,
   parameter int OPC_W = 3,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_operand1,
   input  logic [7:0]               in_operand2,
   input  logic [OPC_W-1:0]         in_opcode,
   input  logic                     issue_en,
   input  logic                     flush,
   output logic [7:0]               operand1,
   output logic [7:0]               operand2,
   output logic [OPC_W-1:0]         opcode,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic [CNT_W-1:0]         issued_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 16 + OPC_W;

   logic [EW-1:0]      mem_q [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [7:0]         op1_q, op1_d;
   logic [7:0]         op2_q, op2_d;
   logic [OPC_W-1:0]   opc_q, opc_d;
   logic               vld_q, vld_d;
   logic               push, pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full && !flush;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && issue_en && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      issued_d = issued_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      opc_d    = opc_q;
      vld_d    = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d              = rd_ptr_q + 1'b1;
            {op1_d, op2_d, opc_d} = mem_q[rd_ptr_q];
            vld_d                 = 1'b1;
            issued_d              = issued_q + 1'b1;
         end
         // Push and pop together leave occupancy unchanged.
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         issued_q <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         opc_q    <= '0;
         vld_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         issued_q <= issued_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         opc_q    <= opc_d;
         vld_q    <= vld_d;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= {in_operand1, in_operand2, in_opcode};
      end
   end

   assign operand1    = op1_q;
   assign operand2    = op2_q;
   assign opcode      = opc_q;
   assign issue_valid = vld_q;
   assign count       = count_q;
   assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_cmd_issuer;

   localparam int DEPTH = 8;
   localparam int OPC_W = 3;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_operand1 = '0;
   logic [7:0]       in_operand2 = '0;
   logic [OPC_W-1:0] in_opcode = '0;
   logic             issue_en = 1'b0;
   logic             flush = 1'b0;
   logic [7:0]       operand1;
   logic [7:0]       operand2;
   logic [OPC_W-1:0] opcode;
   logic             issue_valid;
   logic [3:0]       count;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] issued_cnt;

   alu_cmd_issuer #(.DEPTH(DEPTH), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_operand1(in_operand1), .in_operand2(in_operand2), .in_opcode(in_opcode),
      .issue_en(issue_en), .flush(flush), .operand1(operand1), .operand2(operand2),
      .opcode(opcode), .issue_valid(issue_valid), .count(count), .full(full),
      .empty(empty), .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference model: a queue of commands plus the visible output registers.
   logic [18:0]      mq[$];
   logic [7:0]       m_op1, m_op2;
   logic [2:0]       m_opc;
   logic             m_iv;
   logic [CNT_W-1:0] m_issued;
   bit               m_ok = 0;
   int unsigned      issue_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("issue_valid", 32'(issue_valid), 32'(m_iv));
      chk("operand1", 32'(operand1), 32'(m_op1));
      chk("operand2", 32'(operand2), 32'(m_op2));
      chk("opcode", 32'(opcode), 32'(m_opc));
      chk("issued_cnt", 32'(issued_cnt), 32'(m_issued));
   endtask

   task automatic cyc(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] o, input bit ie, input bit fl, input bit r);
      bit do_push, do_pop;
      in_valid = v; in_operand1 = a; in_operand2 = b; in_opcode = o;
      issue_en = ie; flush = fl; rst = r;
      #1;
      if (m_ok) chk("in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !fl));
      if (r) begin
         mq.delete();
         m_op1 = '0; m_op2 = '0; m_opc = '0; m_iv = 1'b0; m_issued = '0;
         m_ok = 1;
      end else if (fl) begin
         mq.delete();
         m_iv = 1'b0;
      end else begin
         do_push = v && (mq.size() < DEPTH);
         do_pop  = (mq.size() > 0) && ie;
         m_iv = do_pop;
         if (do_pop) begin
            {m_op1, m_op2, m_opc} = mq.pop_front();
            m_issued++;
         end
         if (do_push) mq.push_back({a, b, o});
      end
      @(posedge clk);
      #1;
      if (issue_valid === 1'b1) issue_seen++;
      if (m_ok) check_state();
   endtask

   task automatic idle(input bit ie);
      cyc(1'b0, 8'h00, 8'h00, 3'd0, ie, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      int unsigned base;
      @(posedge clk); #1;

      // Reset then idle
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);

      // Single command: visible after the second edge, then held
      cyc(1'b1, 8'h05, 8'hFD, 3'd2, 1'b1, 1'b0, 1'b0);
      chk("single_not_yet", 32'(issue_valid), 32'd0);
      idle(1'b1);
      chk("single_op1", 32'(operand1), 32'h05);
      chk("single_op2", 32'(operand2), 32'hFD);
      chk("single_valid", 32'(issue_valid), 32'd1);
      idle(1'b1);
      idle(1'b1);

      // Fill while stalled, ninth command refused, then drain in order
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 8'(2*i), 3'(i % 8), 1'b0, 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      cyc(1'b1, 8'hAA, 8'hBB, 3'd7, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         chk("drain_order", 32'(operand1), 32'(i));
      end
      chk("drain_empty", 32'(empty), 32'd1);
      idle(1'b1);

      // Streaming across pointer wrap
      base = 32'(m_issued);
      for (int i = 0; i < 32; i++) begin
         cyc(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b0);
         chk("stream_cnt_le2", 32'(count <= 2), 32'd1);
      end
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("stream_issued", 32'(issued_cnt), 32'(base + 32));

      // Flush mid-burst
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 8'h11, 3'(i), 1'b0, 1'b0, 1'b0);
      base = 32'(issued_cnt);
      cyc(1'b1, 8'h77, 8'h66, 3'd5, 1'b1, 1'b1, 1'b0);
      chk("flush_count", 32'(count), 32'd0);
      idle(1'b1);
      chk("flush_no_issue", 32'(issued_cnt), base);
      cyc(1'b1, 8'h3C, 8'hC3, 3'd6, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      chk("post_flush_op", 32'(operand1), 32'h3C);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h90 + i), 8'h22, 3'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h55, 8'h55, 3'd1, 1'b1, 1'b0, 1'b1);
      issue_seen = 0;
      for (int i = 0; i < 5; i++) idle(1'b1);
      chk("reset_no_issue", issue_seen, 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         cyc(bit'($urandom_range(0, 99) < 60), ra, rb, 3'($urandom),
             bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 99) < 3),
             bit'($urandom_range(0, 99) < 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
